// File: rtl/dual_port_ram_pkg.sv
// Shared types and helpers for dual_port_ram: FSM encoding, byte-enable width and byte parity.
package dual_port_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    // Even parity: the stored bit gives the byte plus its parity bit an even count of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline: RD_LATENCY stages of valid/data/parity-error, one instance per RAM port.
// Data stages only load behind a valid, so the last stage holds the previous result between strobes.
module ram_rd_pipe
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_perr,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_perr
);

    logic                  vld  [RD_LATENCY];
    logic [DATA_WIDTH-1:0] dat  [RD_LATENCY];
    logic                  perr [RD_LATENCY];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld[i]  <= 1'b0;
                dat[i]  <= '0;
                perr[i] <= 1'b0;
            end
        end else begin
            vld[0] <= in_vld;
            if (in_vld) begin
                dat[0]  <= in_data;
                perr[0] <= in_perr;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    dat[i]  <= dat[i-1];
                    perr[i] <= perr[i-1];
                end
            end
        end
    end

    assign out_vld  = vld[RD_LATENCY-1];
    assign out_data = dat[RD_LATENCY-1];
    assign out_perr = vld[RD_LATENCY-1] & perr[RD_LATENCY-1];

endmodule

// File: rtl/dual_port_ram.sv
// Dual-port RAM: port A read/write with byte enables, port B read-only, zero-cleared after every reset.
// Define DUAL_PORT_RAM_PARITY_EN to store and check one even-parity bit per byte.
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH       = 16,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en_a,
    input  logic                    wr_rd_a,
    input  logic [ADDR_WIDTH-1:0]   addr_a,
    input  logic [DATA_WIDTH-1:0]   data_in_a,
    input  logic [DATA_WIDTH/8-1:0] be_a,
    output logic [DATA_WIDTH-1:0]   data_out_a,
    output logic                    out_en_a,
    input  logic                    en_b,
    input  logic [ADDR_WIDTH-1:0]   addr_b,
    output logic [DATA_WIDTH-1:0]   data_out_b,
    output logic                    out_en_b,
    output logic                    busy,
    output logic                    par_err_a,
    output logic                    par_err_b
);

    localparam int                  BE_WIDTH  = be_width(DATA_WIDTH);
    localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      clr_ptr;
    logic                  ready;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0]      idx_a;
    logic [IDX_W-1:0]      idx_b;
    logic                  in_rng_a;
    logic                  in_rng_b;
    logic                  wr_a;
    logic                  rd_a;
    logic                  rd_b;
    logic                  collide;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rd_word_a;
    logic [DATA_WIDTH-1:0] rd_word_b;
    logic                  perr_a;
    logic                  perr_b;

    // Clear sequencer: one zero write per cycle, then hand over to normal operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                clr_ptr <= (clr_ptr == LAST_IDX) ? '0 : clr_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_ptr == LAST_IDX) begin
            state_nxt = READY;
        end
    end

    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        case (state)
            CLEAR:   busy  = 1'b1;
            READY:   ready = 1'b1;
            default: busy  = 1'b1;
        endcase
    end

    assign idx_a    = addr_a[IDX_W-1:0];
    assign idx_b    = addr_b[IDX_W-1:0];
    assign in_rng_a = {1'b0, addr_a} < DEPTH_LIM;
    assign in_rng_b = {1'b0, addr_b} < DEPTH_LIM;
    assign wr_a     = ready & en_a & wr_rd_a;
    assign rd_a     = ready & en_a & ~wr_rd_a;
    assign rd_b     = ready & en_b;
    assign collide  = wr_a & in_rng_a & in_rng_b & (addr_a == addr_b);

    always_comb begin
        merged = mem[idx_a];
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be_a[i]) begin
                merged[8*i +: 8] = data_in_a[8*i +: 8];
            end
        end
    end

    // Out-of-range reads still return a strobe, carrying zero.
    always_comb begin
        rd_word_a = '0;
        rd_word_b = '0;
        if (in_rng_a) begin
            rd_word_a = mem[idx_a];
        end
        if (in_rng_b) begin
            rd_word_b = (collide && WRITE_FIRST != 0) ? merged : mem[idx_b];
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_a && in_rng_a) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be_a[i]) begin
                    mem[idx_a][8*i +: 8] <= data_in_a[8*i +: 8];
                end
            end
        end
    end

`ifdef DUAL_PORT_RAM_PARITY_EN
    logic [BE_WIDTH-1:0] par_mem [DEPTH];
    logic [BE_WIDTH-1:0] merged_par;
    logic [BE_WIDTH-1:0] par_rd_a;
    logic [BE_WIDTH-1:0] par_rd_b;

    function automatic logic [BE_WIDTH-1:0] word_parity(input logic [DATA_WIDTH-1:0] w);
        logic [BE_WIDTH-1:0] p;
        for (int i = 0; i < BE_WIDTH; i++) begin
            p[i] = byte_parity(w[8*i +: 8]);
        end
        return p;
    endfunction

    always_comb begin
        merged_par = par_mem[idx_a];
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be_a[i]) begin
                merged_par[i] = byte_parity(data_in_a[8*i +: 8]);
            end
        end
    end

    always_comb begin
        par_rd_a = '0;
        par_rd_b = '0;
        if (in_rng_a) begin
            par_rd_a = par_mem[idx_a];
        end
        if (in_rng_b) begin
            par_rd_b = (collide && WRITE_FIRST != 0) ? merged_par : par_mem[idx_b];
        end
    end

    assign perr_a = |(par_rd_a ^ word_parity(rd_word_a));
    assign perr_b = |(par_rd_b ^ word_parity(rd_word_b));

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            par_mem[clr_ptr] <= '0;
        end else if (wr_a && in_rng_a) begin
            par_mem[idx_a] <= merged_par;
        end
    end
`else
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_a (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (rd_a),
        .in_data  (rd_word_a),
        .in_perr  (perr_a),
        .out_vld  (out_en_a),
        .out_data (data_out_a),
        .out_perr (par_err_a)
    );

    ram_rd_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) u_pipe_b (
        .clk      (clk),
        .rstn     (rstn),
        .in_vld   (rd_b),
        .in_data  (rd_word_b),
        .in_perr  (perr_b),
        .out_vld  (out_en_b),
        .out_data (data_out_b),
        .out_perr (par_err_b)
    );

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: directed steps plus a randomized phase against a behavioural model.
module tb_dual_port_ram;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int LAT   = 3;
    localparam int WF    = 1;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b1;
    logic          en_a      = 1'b0;
    logic          wr_rd_a   = 1'b0;
    logic [AW-1:0] addr_a    = '0;
    logic [DW-1:0] data_in_a = '0;
    logic [3:0]    be_a      = '0;
    logic          en_b      = 1'b0;
    logic [AW-1:0] addr_b    = '0;
    logic [DW-1:0] data_out_a;
    logic [DW-1:0] data_out_b;
    logic          out_en_a;
    logic          out_en_b;
    logic          busy;
    logic          par_err_a;
    logic          par_err_b;

    always #5 clk = ~clk;

    dual_port_ram #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .RD_LATENCY  (LAT),
        .WRITE_FIRST (WF)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en_a       (en_a),
        .wr_rd_a    (wr_rd_a),
        .addr_a     (addr_a),
        .data_in_a  (data_in_a),
        .be_a       (be_a),
        .data_out_a (data_out_a),
        .out_en_a   (out_en_a),
        .en_b       (en_b),
        .addr_b     (addr_b),
        .data_out_b (data_out_b),
        .out_en_b   (out_en_b),
        .busy       (busy),
        .par_err_a  (par_err_a),
        .par_err_b  (par_err_b)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        pe;
    } rd_t;

    rd_t         qa[$];
    rd_t         qb[$];
    logic [31:0] mmem [DEPTH];
    logic [3:0]  mbad [DEPTH];
    logic [31:0] last_a;
    logic [31:0] last_b;
    int          clr_left;
    int          cyc;
    int          tests;
    int          fails;
    int          pulses_a;
    int          pulses_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    function automatic rd_t model_read(input logic [AW-1:0] a, input logic coll);
        rd_t r;
        r.due = cyc + LAT;
        if (a >= DEPTH) begin
            r.data = '0;
            r.pe   = 1'b0;
        end else if (coll && WF != 0) begin
            r.data = merge(mmem[a[3:0]], data_in_a, be_a);
            r.pe   = |(mbad[a[3:0]] & ~be_a);
        end else begin
            r.data = mmem[a[3:0]];
            r.pe   = |mbad[a[3:0]];
        end
        return r;
    endfunction

    task automatic check_outputs();
        logic ea, eb, pa, pb;
        ea = 1'b0; eb = 1'b0; pa = 1'b0; pb = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            ea = 1'b1; last_a = qa[0].data; pa = qa[0].pe; void'(qa.pop_front());
        end
        if (qb.size() > 0 && qb[0].due == cyc) begin
            eb = 1'b1; last_b = qb[0].data; pb = qb[0].pe; void'(qb.pop_front());
        end
        chk("out_en_a", 32'(out_en_a), 32'(ea));
        chk("out_en_b", 32'(out_en_b), 32'(eb));
        chk("data_out_a", data_out_a, last_a);
        chk("data_out_b", data_out_b, last_b);
        chk("par_err_a", 32'(par_err_a), 32'(pa));
        chk("par_err_b", 32'(par_err_b), 32'(pb));
        chk("busy", 32'(busy), 32'(clr_left != 0));
        if (out_en_a === 1'b1) pulses_a++;
        if (out_en_b === 1'b1) pulses_b++;
    endtask

    // One clock: model consumes the currently driven inputs, then outputs are checked after the edge.
    task automatic step();
        if (clr_left == 0) begin
            if (en_b) qb.push_back(model_read(addr_b, en_a && wr_rd_a && addr_a == addr_b));
            if (en_a && !wr_rd_a) qa.push_back(model_read(addr_a, 1'b0));
            if (en_a && wr_rd_a && addr_a < DEPTH) begin
                mmem[addr_a[3:0]] = merge(mmem[addr_a[3:0]], data_in_a, be_a);
                mbad[addr_a[3:0]] = mbad[addr_a[3:0]] & ~be_a;
            end
        end else begin
            mmem[DEPTH - clr_left] = '0;
            mbad[DEPTH - clr_left] = '0;
            clr_left--;
        end
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        qa.delete();
        qb.delete();
        last_a   = '0;
        last_b   = '0;
        clr_left = DEPTH;
        #2;
        chk("rst_data_out_a", data_out_a, 32'h0);
        chk("rst_data_out_b", data_out_b, 32'h0);
        chk("rst_out_en_a", 32'(out_en_a), 32'h0);
        chk("rst_out_en_b", 32'(out_en_b), 32'h0);
        chk("rst_par_err_a", 32'(par_err_a), 32'h0);
        chk("rst_par_err_b", 32'(par_err_b), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic idle();
        en_a = 1'b0; wr_rd_a = 1'b0; en_b = 1'b0;
    endtask

    task automatic write_a(input int a, input logic [31:0] d, input logic [3:0] be);
        en_a = 1'b1; wr_rd_a = 1'b1; addr_a = AW'(a); data_in_a = d; be_a = be; en_b = 1'b0;
        step();
    endtask

    initial begin
        int          n;
        int          p0;
        int          k;
        logic [6:0]  hist;
        logic [31:0] got [4];
        logic [31:0] acc;
        logic        seen;
        logic        pe_exp;

        tests = 0; fails = 0; cyc = 0; pulses_a = 0; pulses_b = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mmem[i] = '0; mbad[i] = '0;
        end

        // Reset, then busy for exactly DEPTH cycles, then all words read back as zero.
        #1;
        apply_reset();
        n = 0;
        while (busy === 1'b1 && n < 100) begin step(); n++; end
        chk("t1_busy_cycles", n, DEPTH);
        p0 = pulses_b;
        for (int i = 0; i < DEPTH; i++) begin
            en_b = 1'b1; addr_b = AW'(i);
            step();
        end
        idle();
        repeat (LAT + 1) step();
        chk("t1_pulses_b", pulses_b - p0, 16);

        // Byte-enable merge.
        write_a(3, 32'hA5A5_5A5A, 4'b1111);
        write_a(3, 32'h0000_FF00, 4'b0010);
        en_a = 1'b1; wr_rd_a = 1'b0; addr_a = AW'(3);
        step();
        idle();
        repeat (LAT) step();
        chk("t2_merge", data_out_a, 32'hA5A5_FF5A);

        // Back-to-back port B reads emerge in order with LAT-cycle spacing.
        for (int i = 0; i < 4; i++) write_a(i, 32'(10 + i), 4'b1111);
        idle();
        k = 0;
        for (int i = 0; i < 7; i++) begin
            en_b = (i < 4); addr_b = AW'(i);
            step();
            hist[i] = out_en_b;
            if (out_en_b === 1'b1 && k < 4) begin got[k] = data_out_b; k++; end
        end
        chk("t3_pulse_pattern", 32'(hist), 32'(7'b0111100));
        for (int i = 0; i < 4; i++) chk("t3_order", (i < k) ? got[i] : 32'hDEAD_BEEF, 32'(10 + i));

        // Same-cycle write A / read B collision.
        write_a(5, 32'h1111_1111, 4'b1111);
        en_a = 1'b1; wr_rd_a = 1'b1; addr_a = AW'(5); data_in_a = 32'h2222_2222; be_a = 4'b1111;
        en_b = 1'b1; addr_b = AW'(5);
        step();
        idle();
        repeat (LAT) step();
        chk("t4_collision", data_out_b, (WF != 0) ? 32'h2222_2222 : 32'h1111_1111);

        // Reset mid-clear restarts the sequence; requests while busy are dropped.
        apply_reset();
        repeat (7) step();
        apply_reset();
        p0 = pulses_a + pulses_b;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            en_a = 1'b1; wr_rd_a = 1'($urandom_range(0, 1)); addr_a = AW'($urandom_range(0, 15));
            data_in_a = $urandom() | 32'h1; be_a = 4'b1111;
            en_b = 1'b1; addr_b = AW'($urandom_range(0, 15));
            step();
            n++;
        end
        idle();
        chk("t5_busy_cycles", n, DEPTH);
        chk("t5_no_pulses", (pulses_a + pulses_b) - p0, 0);
        acc = '0;
        for (int i = 0; i < DEPTH + LAT; i++) begin
            en_a = (i < DEPTH); wr_rd_a = 1'b0; addr_a = AW'(i % DEPTH);
            step();
            if (out_en_a === 1'b1) acc = acc | data_out_a;
        end
        idle();
        chk("t5_all_zero", acc, 32'h0);

        // Parity error on a corrupted word.
        write_a(2, 32'h1234_5678, 4'b1111);
        idle();
        step();
`ifdef DUAL_PORT_RAM_PARITY_EN
        dut.mem[2][0] = ~dut.mem[2][0];
        mmem[2][0]    = ~mmem[2][0];
        mbad[2][0]    = ~mbad[2][0];
        pe_exp        = 1'b1;
`else
        pe_exp        = 1'b0;
`endif
        seen = 1'b0;
        en_a = 1'b1; wr_rd_a = 1'b0; addr_a = AW'(2);
        step();
        idle();
        for (int i = 0; i < LAT; i++) begin
            step();
            if (out_en_a === 1'b1 && par_err_a === 1'b1) seen = 1'b1;
        end
        chk("t6_par_err_a", 32'(seen), 32'(pe_exp));

        // Out-of-range write is dropped and does not alias; out-of-range read returns zero.
        write_a(20, 32'hCAFE_F00D, 4'b1111);
        en_a = 1'b1; wr_rd_a = 1'b0; addr_a = AW'(4);
        en_b = 1'b1; addr_b = AW'(20);
        step();
        idle();
        repeat (LAT) step();
        chk("oor_read_b", data_out_b, 32'h0);
        chk("oor_no_alias_a", data_out_a, 32'h0);

        // Randomized traffic on both ports.
        for (int i = 0; i < 400; i++) begin
            en_a      = 1'($urandom_range(0, 1));
            wr_rd_a   = 1'($urandom_range(0, 1));
            addr_a    = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(16, 31)) : AW'($urandom_range(0, 15));
            data_in_a = $urandom();
            be_a      = 4'($urandom_range(0, 15));
            en_b      = 1'($urandom_range(0, 1));
            addr_b    = ($urandom_range(0, 2) == 0) ? addr_a : AW'($urandom_range(0, 31));
            step();
        end
        idle();
        repeat (LAT + 1) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- Parametrised successor to the team's single-port RAM.
- Port A reads and writes, with byte enables. Port B is read-only.
- Single clock; configurable read latency; selectable collision policy.
- Memory is zero-filled by a hardware clear sequence after every reset.
- Used as the generic on-chip buffer; its out_en style valid strobes match the existing RAM testbenches.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4, address width.
- DEPTH, 16, number of words; 1..2**ADDR_WIDTH.
- RD_LATENCY, 1, cycles from an accepted read to its valid strobe; legal 1..4.
- WRITE_FIRST, 1, collision policy: 1 = a port-B read of the address port A writes that cycle returns the new data; 0 = returns the old data.

Ports:
- clk, input, 1, the block's single clock; all logic on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- en_a, input, 1, port A request.
- wr_rd_a, input, 1, 1 = write, 0 = read.
- addr_a, input, ADDR_WIDTH, port A address.
- data_in_a, input, DATA_WIDTH, write data.
- be_a, input, DATA_WIDTH/8, byte enables; bit i covers byte i.
- data_out_a, output, DATA_WIDTH, port A read data.
- out_en_a, output, 1, port A read-valid strobe.
- en_b, input, 1, port B read request.
- addr_b, input, ADDR_WIDTH, port B address.
- data_out_b, output, DATA_WIDTH, port B read data.
- out_en_b, output, 1, port B read-valid strobe.
- busy, output, 1, clear sequence in progress.
- par_err_a, output, 1, parity error on port A read; see Optional Feature.
- par_err_b, output, 1, parity error on port B read; see Optional Feature.

Behaviour:
- Reset (rstn low, asynchronous):
  - data_out_a, data_out_b = 0.
  - out_en_a, out_en_b, par_err_a, par_err_b = 0.
  - All read-pipeline valid bits = 0.
  - FSM enters CLEAR with the clear pointer at 0; busy = 1.
  - Array contents are not reset asynchronously.
- FSM state CLEAR: after rstn deasserts, writes 0 to address ptr once per cycle, for ptr = 0..DEPTH-1. Moves to READY on the edge that writes DEPTH-1. busy = 1 for exactly DEPTH cycles after reset release.
- FSM state READY: busy = 0; requests are accepted.
- While busy = 1: en_a and en_b are ignored, not queued; no out_en pulses.
- Reset mid-clear: the clear restarts from address 0 after reset release.
- Port A write (en_a=1, wr_rd_a=1): on the edge, each byte with be_a[i]=1 is replaced; other bytes keep their value. A write produces no out_en_a.
- Reads (en_x=1, plus wr_rd_a=0 for port A):
  - Fully pipelined; one request per port per cycle.
  - out_en_x pulses for one cycle exactly RD_LATENCY edges after the request edge.
  - data_out_x is valid during that pulse.
  - Results emerge in request order.
  - data_out_x holds its last value between pulses.
- Collision (port A writes address X while port B reads X in the same cycle): WRITE_FIRST=1 returns the byte-merged new word; WRITE_FIRST=0 returns the pre-write word.
- Address >= DEPTH: writes are dropped; reads still pulse out_en and return 0.
- Both ports reading the same address: both return identical data; no arbitration.

Optional Feature:
- Macro DUAL_PORT_RAM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte and is written only with its byte.
  - CLEAR writes parity 0.
  - Each read recomputes parity; par_err_x pulses coincident with out_en_x if any byte mismatches.
  - data_out_x is still delivered unchanged.
- Undefined: no parity storage; par_err_a and par_err_b are tied to 0.

Decomposition:
- Package dual_port_ram_pkg holds:
  - the FSM state encoding: CLEAR, READY;
  - the BE_WIDTH = DATA_WIDTH/8 derivation helper;
  - the parity function.
- Sub-module ram_rd_pipe: an RD_LATENCY-stage valid/data/parity-error shift register, instantiated once per port.

Test Plan:
1. Release reset -> busy = 1 for exactly 16 cycles; then read addresses 0..15 on port B -> all return 0, 16 out_en_b pulses.
2. Write addr 3 = A5A5_5A5A with be 1111, then write addr 3 = 0000_FF00 with be 0010, then read addr 3 -> A5A5_FF5A.
3. RD_LATENCY=3; port B reads addr 0..3 on consecutive cycles (pre-written 10,11,12,13) -> out_en_b high for 4 consecutive cycles, starting on the 3rd edge after the first request; data 10,11,12,13 in order.
4. Addr 5 = 1111_1111; same cycle, port A writes 2222_2222 and port B reads 5 -> WRITE_FIRST=1 returns 2222_2222; WRITE_FIRST=0 returns 1111_1111.
5. Assert rstn 7 cycles into CLEAR, release -> busy for 16 more cycles; en_a and en_b requests during busy -> no out_en pulses, no writes.
6. With DUAL_PORT_RAM_PARITY_EN, bench flips stored bit 0 of addr 2 by hierarchical force; read addr 2 on port A -> par_err_a pulses with out_en_a. Without the macro -> par_err_a stays 0.
